// File: rtl/pixel_output.sv
// Final two-stage pixel pipeline: ROM fetch, dark-room mask, colour priority and fade-in gain.
// Define PIXEL_OUTPUT_FADE_EN to build the fade FSM; otherwise the gain is fixed at unity.
module pixel_output #(
    parameter logic [11:0] BG_COLOR = 12'h000,
    parameter int          LIGHT_R  = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pclk_en,
    input  logic [9:0]  h_cnt,
    input  logic [9:0]  v_cnt,
    input  logic        valid,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [16:0] pixel_addr,
    input  logic        notBlank,
    input  logic [3:0]  state,
    input  logic        isDark,
    input  logic [8:0]  player_x,
    input  logic [8:0]  player_y,
    output logic [16:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        hsync,
    output logic        vsync
);

    localparam logic signed [9:0] RADIUS = 10'(LIGHT_R);

    // Pixel position halved into 320x240 space, compared against the player.
    logic [9:0]        hx, vy;
    logic signed [9:0] dx, dy, adx, ady;
    logic              dark_state, dark;

    assign hx  = h_cnt >> 1;
    assign vy  = v_cnt >> 1;
    assign dx  = $signed(hx) - $signed({1'b0, player_x});
    assign dy  = $signed(vy) - $signed({1'b0, player_y});
    assign adx = dx[9] ? -dx : dx;
    assign ady = dy[9] ? -dy : dy;

    assign dark_state = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
    assign dark       = isDark && dark_state && ((adx > RADIUS) || (ady > RADIUS));

    // Stage 1
    logic nb_d, valid_d, hs_d, vs_d, dark_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            nb_d     <= 1'b0;
            valid_d  <= 1'b0;
            hs_d     <= 1'b1;
            vs_d     <= 1'b1;
            dark_d   <= 1'b0;
        end else if (pclk_en) begin
            rom_addr <= pixel_addr;
            nb_d     <= notBlank;
            valid_d  <= valid;
            hs_d     <= hsync_in;
            vs_d     <= vsync_in;
            dark_d   <= dark;
        end
    end

    logic [3:0] level;

`ifdef PIXEL_OUTPUT_FADE_EN
    typedef enum logic {FADING, STEADY} fade_t;

    fade_t      fade_state, fade_next;
    logic [3:0] level_next, prev_state;
    logic       vs_fall;

    // vs_d holds vsync_in from the previous strobe, so this is the strobe-sampled edge.
    assign vs_fall = vs_d && !vsync_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fade_state <= FADING;
            level      <= 4'd0;
            prev_state <= 4'd0;
        end else if (pclk_en) begin
            fade_state <= fade_next;
            level      <= level_next;
            prev_state <= state;
        end
    end

    always_comb begin
        fade_next  = fade_state;
        level_next = level;
        if (state != prev_state) begin
            fade_next  = FADING;
            level_next = 4'd0;
        end else if (fade_state == FADING && vs_fall) begin
            level_next = level + 4'd1;
            if (level == 4'd14) fade_next = STEADY;
        end
    end
`else
    assign level = 4'd15;
`endif

    function automatic logic [3:0] scale(input logic [3:0] c, input logic [3:0] lvl);
        logic [7:0] p;
        p = {4'd0, c} * ({4'd0, lvl} + 8'd1);
        return 4'(p >> 4);
    endfunction

    logic [11:0] pix_col;

    always_comb begin
        pix_col = rom_data;
        if (!valid_d)      pix_col = 12'h000;
        else if (dark_d)   pix_col = 12'h000;
        else if (!nb_d)    pix_col = BG_COLOR;
    end

    // Stage 2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_r <= 4'd0;
            vga_g <= 4'd0;
            vga_b <= 4'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pclk_en) begin
            vga_r <= scale(pix_col[11:8], level);
            vga_g <= scale(pix_col[7:4], level);
            vga_b <= scale(pix_col[3:0], level);
            hsync <= hs_d;
            vsync <= vs_d;
        end
    end

endmodule
